// File: rtl/grf_wb_port_pkg.sv
// Shared types and constants for the W-stage register file port.
// Trace entries pack {pc, addr, data} into one 69-bit word.
package grf_wb_port_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int TRACE_W  = 69;
    localparam int DATA_LSB = 0;
    localparam int DATA_MSB = 31;
    localparam int ADDR_LSB = 32;
    localparam int ADDR_MSB = 36;
    localparam int PC_LSB   = 37;
    localparam int PC_MSB   = 68;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } trace_t;

    function automatic trace_t pack_trace(
        input logic [31:0] pc,
        input logic [4:0]  addr,
        input logic [31:0] data
    );
        trace_t t;
        t.pc   = pc;
        t.addr = addr;
        t.data = data;
        return t;
    endfunction

endpackage

// File: rtl/grf_trace_fifo.sv
// Synchronous FIFO for the commit trace; registered head, no fall-through.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module grf_trace_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!w_full || w_pop);
    assign w_drop  = i_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_data     = r_mem[r_rptr];
    assign o_count    = r_count;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/grf_wb_port.sv
// 32x32 register file written from W, read by D with same-cycle bypass.
// Every write (including to x0) is also queued into a commit trace FIFO.
module grf_wb_port
    import grf_wb_port_pkg::*;
#(
    parameter int TRACE_DEPTH = 8,
    parameter int CNT_W       = $clog2(TRACE_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             W_GRF_WE,
    input  logic [4:0]       W_GRF_A3,
    input  logic [31:0]      W_GRF_Wdata,
    input  logic [31:0]      W_PC,
    input  logic [4:0]       D_GRF_A1,
    input  logic [4:0]       D_GRF_A2,
    output logic [31:0]      D_GRF_RD1,
    output logic [31:0]      D_GRF_RD2,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [31:0]      trace_pc,
    output logic [4:0]       trace_addr,
    output logic [31:0]      trace_data,
    output logic [CNT_W-1:0] trace_count,
    output logic             trace_overflow
);

    logic [31:0] r_grf [32];

    logic   w_empty;
    trace_t w_in;
    trace_t w_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_grf[i] <= '0;
            end
        end else if (W_GRF_WE && (W_GRF_A3 != REG_ZERO)) begin
            r_grf[W_GRF_A3] <= W_GRF_Wdata;
        end
    end

    // x0 wins over bypass so a traced x0 write never leaks into reads
    always_comb begin
        D_GRF_RD1 = r_grf[D_GRF_A1];
        if (D_GRF_A1 == REG_ZERO) begin
            D_GRF_RD1 = '0;
        end else if (W_GRF_WE && (W_GRF_A3 == D_GRF_A1)) begin
            D_GRF_RD1 = W_GRF_Wdata;
        end
    end

    always_comb begin
        D_GRF_RD2 = r_grf[D_GRF_A2];
        if (D_GRF_A2 == REG_ZERO) begin
            D_GRF_RD2 = '0;
        end else if (W_GRF_WE && (W_GRF_A3 == D_GRF_A2)) begin
            D_GRF_RD2 = W_GRF_Wdata;
        end
    end

    assign w_in = pack_trace(W_PC, W_GRF_A3, W_GRF_Wdata);

    grf_trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (TRACE_DEPTH),
        .CNT_W (CNT_W)
    ) u_trace_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (W_GRF_WE),
        .i_pop      (trace_ready),
        .i_data     (w_in),
        .o_data     (w_head),
        .o_empty    (w_empty),
        .o_count    (trace_count),
        .o_overflow (trace_overflow)
    );

    assign trace_valid = !w_empty;
    assign trace_pc    = w_head.pc;
    assign trace_addr  = w_head.addr;
    assign trace_data  = w_head.data;

endmodule

// File: tb/tb_grf_wb_port.sv
// Directed and random bench for grf_wb_port against a queue/array model.
// Inputs change 1ns after the rising edge; outputs are checked before the next.
module tb_grf_wb_port;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          W_GRF_WE;
    logic [4:0]    W_GRF_A3;
    logic [31:0]   W_GRF_Wdata;
    logic [31:0]   W_PC;
    logic [4:0]    D_GRF_A1;
    logic [4:0]    D_GRF_A2;
    logic [31:0]   D_GRF_RD1;
    logic [31:0]   D_GRF_RD2;
    logic          trace_valid;
    logic          trace_ready;
    logic [31:0]   trace_pc;
    logic [4:0]    trace_addr;
    logic [31:0]   trace_data;
    logic [CW-1:0] trace_count;
    logic          trace_overflow;

    grf_wb_port #(.TRACE_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .W_GRF_WE       (W_GRF_WE),
        .W_GRF_A3       (W_GRF_A3),
        .W_GRF_Wdata    (W_GRF_Wdata),
        .W_PC           (W_PC),
        .D_GRF_A1       (D_GRF_A1),
        .D_GRF_A2       (D_GRF_A2),
        .D_GRF_RD1      (D_GRF_RD1),
        .D_GRF_RD2      (D_GRF_RD2),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_addr     (trace_addr),
        .trace_data     (trace_data),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_rf [32];
    logic        m_ovf;
    int          checks;
    int          failures;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (W_GRF_WE && W_GRF_A3 == a) return W_GRF_Wdata;
        return m_rf[a];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".rd1"}, D_GRF_RD1, exp_rd(D_GRF_A1));
        chk({tag, ".rd2"}, D_GRF_RD2, exp_rd(D_GRF_A2));
        chk({tag, ".valid"}, 32'(trace_valid), 32'(mq.size() != 0));
        chk({tag, ".count"}, 32'(trace_count), 32'(mq.size()));
        chk({tag, ".ovf"}, 32'(trace_overflow), 32'(m_ovf));
        if (mq.size() != 0) begin
            chk({tag, ".pc"}, trace_pc, mq[0].pc);
            chk({tag, ".addr"}, 32'(trace_addr), 32'(mq[0].a));
            chk({tag, ".data"}, trace_data, mq[0].d);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] a3,
                         input logic [31:0] wd, input logic [31:0] pc,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic rdy);
        W_GRF_WE    = we;
        W_GRF_A3    = a3;
        W_GRF_Wdata = wd;
        W_PC        = pc;
        D_GRF_A1    = a1;
        D_GRF_A2    = a2;
        trace_ready = rdy;
        #1;
    endtask

    task automatic tick();
        ent_t e;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (W_GRF_WE && W_GRF_A3 != 5'd0) m_rf[W_GRF_A3] = W_GRF_Wdata;
            if (mq.size() != 0 && trace_ready) void'(mq.pop_front());
            if (W_GRF_WE) begin
                e.pc = W_PC;
                e.a  = W_GRF_A3;
                e.d  = W_GRF_Wdata;
                if (mq.size() < DEPTH) mq.push_back(e);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd5, 1'b1);
            check_all(tag);
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_ovf    = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;

        @(posedge clk);
        #1;
        do_reset();

        drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd0, 1'b0);
        check_all("reset");
        chk("reset.rd1_zero", D_GRF_RD1, 32'd0);
        chk("reset.count_zero", 32'(trace_count), 32'd0);

        drive(1'b1, 5'd5, 32'h12345678, 32'h3000, 5'd5, 5'd0, 1'b0);
        chk("bypass.rd1", D_GRF_RD1, 32'h12345678);
        check_all("bypass");
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd0, 1'b0);
        chk("stored.rd1", D_GRF_RD1, 32'h12345678);
        chk("stored.pc", trace_pc, 32'h3000);
        check_all("stored");

        drive(1'b1, 5'd0, 32'hFFFFFFFF, 32'h3004, 5'd0, 5'd5, 1'b0);
        chk("x0.rd1_now", D_GRF_RD1, 32'd0);
        check_all("x0w");
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        chk("x0.rd1_after", D_GRF_RD1, 32'd0);
        chk("x0.count", 32'(trace_count), 32'd2);
        check_all("x0r");
        drain("x0drain", 3);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 5'(i + 1), 32'hA000 + 32'(i), 32'h4000 + 32'(4 * i),
                  5'(i + 1), 5'd1, 1'b0);
            check_all("fill");
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd8, 1'b0);
        chk("ovf.count", 32'(trace_count), 32'd8);
        chk("ovf.flag", 32'(trace_overflow), 32'd1);
        check_all("ovf");
        drain("ovfdrain", 9);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(i + 10), 32'hB000 + 32'(i), 32'h5000 + 32'(4 * i),
                  5'd0, 5'd0, 1'b0);
            tick();
        end
        drive(1'b1, 5'd20, 32'hBEEF, 32'h5100, 5'd20, 5'd10, 1'b1);
        check_all("fullpp");
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd20, 5'd10, 1'b0);
        chk("fullpp.count", 32'(trace_count), 32'd8);
        chk("fullpp.ovf", 32'(trace_overflow), 32'd0);
        check_all("fullpp2");
        drain("fullppdrain", 9);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd7, 32'hC000 + 32'(i), 32'h6000, 5'd7, 5'd0, 1'b0);
            tick();
        end
        reset = 1'b1;
        drive(1'b1, 5'd7, 32'hDEAD, 32'h6100, 5'd7, 5'd0, 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd7, 5'd0, 1'b0);
        chk("rst3.count", 32'(trace_count), 32'd0);
        chk("rst3.valid", 32'(trace_valid), 32'd0);
        chk("rst3.rd1", D_GRF_RD1, 32'd0);
        check_all("rst3");

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  5'($urandom_range(0, 31)), $urandom, $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                      : ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 3) == 0) D_GRF_A1 = W_GRF_A3;
            #1;
            check_all("rand");
            tick();
        end
        drain("randdrain", DEPTH + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
